alu_serial_ctrl: RTL and testbench

- Bit-serial N-bit ALU built around one alu1bit instance; it is the stage directly upstream of alu1bit.
- Accepts two N-bit operands and an opcode via a start/ready handshake.
- Feeds alu1bit one bit per clock, LSB first, and keeps the carry in a flip-flop between bits.
- Shifts each sum bit into a result register and flags completion with a one-cycle done pulse.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu1bit.sv | 31 +++
 rtl/alu_serial_ctrl.sv | 107 ++++++++++
 tb/tb_alu_serial_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, alu1bit code and FSM state definitions
// for the bit-serial ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  localparam logic [1:0] ALU1_AND = 2'b00;
  localparam logic [1:0] ALU1_OR  = 2'b01;
  localparam logic [1:0] ALU1_ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // SUB reuses the adder on an inverted b bit
  function automatic logic [1:0] alu1_code(input op_t op);
    logic [1:0] code;
    code = ALU1_ADD;
    unique case (op)
      OP_AND: code = ALU1_AND;
      OP_OR:  code = ALU1_OR;
      OP_ADD: code = ALU1_ADD;
      OP_SUB: code = ALU1_ADD;
      default: code = ALU1_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: AND, OR and full-add.
// Purely combinational; the caller keeps the carry.
import alu_pkg::*;

module alu1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    unique case (op)
      ALU1_AND: s = a & b;
      ALU1_OR:  s = a | b;
      ALU1_ADD: begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
      default: begin
        s    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial N-bit ALU controller: feeds alu1bit LSB first,
// carries between bits in a flop, shifts sums into result.
import alu_pkg::*;

module alu_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         done
);

  localparam int CW = $clog2(N);

  state_t         r_state, w_state_d;
  op_t            r_op, w_op_d;
  logic [N-1:0]   r_a_sh, w_a_d;
  logic [N-1:0]   r_b_sh, w_b_d;
  logic [N-1:0]   r_result, w_result_d;
  logic [CW-1:0]  r_cnt, w_cnt_d;
  logic           r_carry, w_carry_d;
  logic           w_is_sub;
  logic           w_is_arith;
  logic           w_s;
  logic           w_cout;

  assign w_is_sub   = (r_op == OP_SUB);
  assign w_is_arith = (r_op == OP_ADD) || w_is_sub;

  alu1bit u_alu1bit (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0] ^ w_is_sub),
    .cin  (r_carry),
    .op   (alu1_code(r_op)),
    .s    (w_s),
    .cout (w_cout)
  );

  always_comb begin
    w_state_d  = r_state;
    w_op_d     = r_op;
    w_a_d      = r_a_sh;
    w_b_d      = r_b_sh;
    w_result_d = r_result;
    w_cnt_d    = r_cnt;
    w_carry_d  = r_carry;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_a_d     = a;
          w_b_d     = b;
          w_op_d    = op_t'(op);
          w_carry_d = (op_t'(op) == OP_SUB);
          w_cnt_d   = '0;
          w_state_d = RUN;
        end
      end
      RUN: begin
        w_a_d      = r_a_sh >> 1;
        w_b_d      = r_b_sh >> 1;
        w_result_d = {w_s, r_result[N-1:1]};
        w_carry_d  = w_is_arith ? w_cout : 1'b0;
        w_cnt_d    = r_cnt + 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          w_state_d = DONE;
        end
      end
      DONE: w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_AND;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_op     <= w_op_d;
      r_a_sh   <= w_a_d;
      r_b_sh   <= w_b_d;
      r_result <= w_result_d;
      r_cnt    <= w_cnt_d;
      r_carry  <= w_carry_d;
    end
  end

  assign ready  = (r_state == IDLE);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (N=8) with
// hand-computed expected results.
module tb_alu_serial_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ready;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] result;
  logic         carry;
  logic         zero;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ready  (ready),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .done   (done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is #1 after an edge. glitch>0 pulses start with
  // new operands on that RUN cycle index (0-based).
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] er, input logic ec,
                        input logic ez, input int glitch);
    int lat;
    int extra;
    check({tag, " ready"}, 32'(ready), 32'd1);
    op = o; a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      start = (glitch != 0 && lat == glitch);
      if (start) begin
        a = 8'h0F; b = 8'h0F; op = 2'b10;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " carry"}, 32'(carry), 32'(ec));
    check({tag, " zero"}, 32'(zero), 32'(ez));
    check({tag, " ready in done"}, 32'(ready), 32'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check({tag, " extra done"}, 32'(extra), 32'd0);
    check({tag, " result held"}, 32'(result), 32'(er));
  endtask

  initial begin
    int extra;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst ready", 32'(ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'h00);
    check("rst carry", 32'(carry), 32'd0);
    check("rst zero", 32'(zero), 32'd1);

    run_op("add1", 2'b10, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 0);
    run_op("add2", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 0);
    run_op("sub1", 2'b11, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 0);
    run_op("sub2", 2'b11, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 0);
    run_op("and", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0);
    run_op("or", 2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 0);
    run_op("or glitch", 2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 2);

    op = 2'b10; a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", 32'(result), 32'h00);
    check("midrst carry", 32'(carry), 32'd0);
    check("midrst zero", 32'(zero), 32'd1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("midrst no done", 32'(extra), 32'd0);

    run_op("add after rst", 2'b10, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
